// File: rtl/abft_acc_array.sv
// Skewed multi-column checksum window accumulator for the ABFT checker.
// One shared beat counter drives per-column valid/last skew pipes; each lane sums a window and flags overflow.
module abft_acc_array #(
    parameter int arraySize   = 4,
    parameter int numChannels = 4,
    parameter int aBits       = 8,
    parameter int zBits       = 12,
    parameter int windowLen   = 4,
    parameter int cntWidth    = (windowLen > 1) ? $clog2(windowLen) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   valid,
    input  logic                                   sat_en,
    input  logic [arraySize*numChannels*aBits-1:0] data_in,
    output logic [arraySize*numChannels*zBits-1:0] acc_out,
    output logic [arraySize*numChannels-1:0]       ovf_out,
    output logic [arraySize-1:0]                   acc_valid,
    output logic [cntWidth-1:0]                    selector_out,
    output logic                                   clear_out
);

    localparam logic [cntWidth-1:0] CNT_LAST = cntWidth'(windowLen - 1);

    // Returns {overflow, next accumulator}; saturation pins the sum at all-ones.
    function automatic logic [zBits:0] acc_step(
        input logic [zBits-1:0] acc,
        input logic [aBits-1:0] x,
        input logic             sat,
        input logic             ovf_in
    );
        logic [zBits:0]   sum;
        logic [zBits-1:0] nxt;
        sum = {1'b0, acc} + {{(zBits + 1 - aBits){1'b0}}, x};
        if (sat && sum[zBits]) nxt = '1;
        else                   nxt = sum[zBits-1:0];
        return {ovf_in | sum[zBits], nxt};
    endfunction

    logic [cntWidth-1:0]  cnt_p0;
    logic                 last;
    logic [arraySize-1:0] v_pipe;
    logic [arraySize-1:0] l_pipe;

    assign last         = valid && (cnt_p0 == CNT_LAST);
    assign selector_out = cnt_p0;
    assign clear_out    = l_pipe[arraySize-1] & v_pipe[arraySize-1];

    // Stage 0: window beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (valid) begin
            cnt_p0 <= last ? '0 : cnt_p0 + 1'b1;
        end
    end

    // Skew chain: stage k lines valid/last up with column k's data
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
            l_pipe <= '0;
        end else begin
            v_pipe[0] <= valid;
            l_pipe[0] <= last;
            for (int k = 1; k < arraySize; k++) begin
                v_pipe[k] <= v_pipe[k-1];
                l_pipe[k] <= l_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) acc_valid <= '0;
        else     acc_valid <= v_pipe & l_pipe;
    end

    for (genvar k = 0; k < arraySize; k++) begin : g_col
        for (genvar c = 0; c < numChannels; c++) begin : g_ch
            localparam int L = k * numChannels + c;

            logic [zBits-1:0] acc_p1;
            logic             ovf_p1;
            logic [zBits-1:0] res_p2;
            logic             ovf_p2;
            logic [zBits:0]   step;

            assign step = acc_step(acc_p1, data_in[L*aBits +: aBits], sat_en, ovf_p1);

            // Stage 1/2: running sum, then window result on the last beat
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_p1 <= '0;
                    ovf_p1 <= 1'b0;
                    res_p2 <= '0;
                    ovf_p2 <= 1'b0;
                end else if (v_pipe[k]) begin
                    if (l_pipe[k]) begin
                        res_p2 <= step[zBits-1:0];
                        ovf_p2 <= step[zBits];
                        acc_p1 <= '0;
                        ovf_p1 <= 1'b0;
                    end else begin
                        acc_p1 <= step[zBits-1:0];
                        ovf_p1 <= step[zBits];
                    end
                end
            end

            assign acc_out[L*zBits +: zBits] = res_p2;
            assign ovf_out[L]                = ovf_p2;
        end
    end

endmodule

// File: tb/tb_abft_acc_array.sv
// Bench for abft_acc_array: three configurations share one beat stream and are
// compared each cycle against a window-sum model built from the recorded beat history.
module tb_abft_acc_array;

    localparam int NCYC = 1024;

    logic clk = 1'b0;
    logic rst, valid, sat_en;
    logic [127:0] d0, d1;
    logic [15:0]  d2;
    logic [191:0] acc0;
    logic [143:0] acc1;
    logic [23:0]  acc2;
    logic [15:0]  ovf0, ovf1;
    logic [1:0]   ovf2;
    logic [3:0]   av0, av1;
    logic [1:0]   av2;
    logic [1:0]   sel0, sel1;
    logic         sel2;
    logic         clr0, clr1, clr2;

    always #5 clk = ~clk;

    abft_acc_array u0 (
        .clk(clk), .rst(rst), .valid(valid), .sat_en(sat_en), .data_in(d0),
        .acc_out(acc0), .ovf_out(ovf0), .acc_valid(av0), .selector_out(sel0), .clear_out(clr0)
    );

    abft_acc_array #(.zBits(9)) u1 (
        .clk(clk), .rst(rst), .valid(valid), .sat_en(sat_en), .data_in(d1),
        .acc_out(acc1), .ovf_out(ovf1), .acc_valid(av1), .selector_out(sel1), .clear_out(clr1)
    );

    abft_acc_array #(.arraySize(2), .numChannels(1), .windowLen(1)) u2 (
        .clk(clk), .rst(rst), .valid(valid), .sat_en(sat_en), .data_in(d2),
        .acc_out(acc2), .ovf_out(ovf2), .acc_valid(av2), .selector_out(sel2), .clear_out(clr2)
    );

    int DK[3] = '{4, 4, 2};
    int DC[3] = '{4, 4, 1};
    int DZ[3] = '{12, 9, 12};
    int DW[3] = '{4, 4, 1};

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  nb    = 0;
    int  last_rst = -1;
    bit  armed = 0;
    bit  hv[NCYC];
    bit  hs[NCYC];
    int  bidx[NCYC];
    int  hd[NCYC][4][4];
    int  exp_acc[3][4][4];
    bit  exp_ovf[3][4][4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
        end
    endtask

    function automatic bit is_last(input int d, input int t);
        if (t < 0 || t <= last_rst) return 1'b0;
        return hv[t] && (bidx[t] % DW[d] == 0);
    endfunction

    // Closed-form window result: plain sum of the window's beats, then wrap or clamp.
    task automatic window_result(input int d, input int t, input int k, input int c);
        int sum, got, tt, lim;
        sum = 0; got = 0; tt = t;
        while (got < DW[d]) begin
            if (hv[tt]) begin
                sum += hd[tt][k][c];
                got++;
            end
            tt--;
        end
        lim = 1 << DZ[d];
        exp_ovf[d][k][c] = (sum >= lim);
        if (sum < lim)  exp_acc[d][k][c] = sum;
        else if (hs[t]) exp_acc[d][k][c] = lim - 1;
        else            exp_acc[d][k][c] = sum % lim;
    endtask

    task automatic check_dut(input int d, input logic [191:0] accb, input logic [15:0] ovfb,
                             input logic [3:0] avb, input logic [1:0] selb, input logic clrb);
        logic [191:0] sh;
        logic [31:0]  mask;
        bit           pulse;
        int           L;
        mask = (32'd1 << DZ[d]) - 32'd1;
        for (int k = 0; k < DK[d]; k++) begin
            pulse = is_last(d, cyc - k - 2);
            if (pulse)
                for (int c = 0; c < DC[d]; c++) window_result(d, cyc - k - 2, k, c);
            chk($sformatf("d%0d_acc_valid_k%0d_cyc%0d", d, k, cyc), 32'(avb[k]), 32'(pulse));
            for (int c = 0; c < DC[d]; c++) begin
                L  = k * DC[d] + c;
                sh = accb >> (L * DZ[d]);
                chk($sformatf("d%0d_acc_k%0d_c%0d_cyc%0d", d, k, c, cyc), sh[31:0] & mask,
                    32'(exp_acc[d][k][c]));
                chk($sformatf("d%0d_ovf_k%0d_c%0d_cyc%0d", d, k, c, cyc), 32'(ovfb[L]),
                    32'(exp_ovf[d][k][c]));
            end
        end
        chk($sformatf("d%0d_selector_cyc%0d", d, cyc), 32'(selb), 32'(nb % DW[d]));
        chk($sformatf("d%0d_clear_cyc%0d", d, cyc), 32'(clrb), 32'(is_last(d, cyc - DK[d])));
    endtask

    task automatic step(input bit v, input bit r, input bit rnd, input int val);
        int s, x;
        if (cyc >= NCYC) begin
            $display("FAIL cycle_budget: got %0d, want < %0d", cyc, NCYC);
            $fatal(1, "cycle budget exhausted");
        end
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++)
                hd[cyc][k][c] = rnd ? int'($urandom_range(0, 255)) : val;
        @(posedge clk);
        #1;
        valid = v;
        rst   = r;
        for (int k = 0; k < 4; k++) begin
            s = cyc - k - 1;
            for (int c = 0; c < 4; c++) begin
                x = (s >= 0 && hv[s]) ? hd[s][k][c] : int'($urandom_range(0, 255));
                d0[(k*4+c)*8 +: 8] = 8'(x);
                d1[(k*4+c)*8 +: 8] = 8'(x);
                if (k < 2 && c == 0) d2[k*8 +: 8] = 8'(x);
            end
        end
        @(negedge clk);
        if (armed) begin
            check_dut(0, acc0, ovf0, av0, sel0, clr0);
            check_dut(1, 192'(acc1), ovf1, av1, sel1, clr1);
            check_dut(2, 192'(acc2), 16'(ovf2), 4'(av2), 2'(sel2), clr2);
        end
        if (r) begin
            last_rst = cyc;
            nb       = 0;
            armed    = 1;
            hv[cyc]  = 0;
            for (int d = 0; d < 3; d++)
                for (int k = 0; k < 4; k++)
                    for (int c = 0; c < 4; c++) begin
                        exp_acc[d][k][c] = 0;
                        exp_ovf[d][k][c] = 0;
                    end
        end else begin
            hv[cyc] = v;
            if (v) nb++;
        end
        bidx[cyc] = nb;
        hs[cyc]   = sat_en;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sat_en = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);

        repeat (4) step(1, 0, 0, 1);
        idle(8);
        chk("tp_ones_k0c0", 32'(acc0[11:0]), 32'd4);
        chk("tp_ones_k3c3", 32'(acc0[15*12 +: 12]), 32'd4);
        chk("tp_ones_ovf", 32'(ovf0), 32'd0);

        step(1, 0, 0, 10);
        step(0, 0, 0, 0);
        step(1, 0, 0, 20);
        step(1, 0, 0, 30);
        step(0, 0, 0, 0);
        step(1, 0, 0, 40);
        idle(8);
        chk("tp_gaps_k2c1", 32'(acc0[9*12 +: 12]), 32'd100);

        repeat (4) step(1, 0, 0, 255);
        idle(8);
        chk("tp_wrap_acc", 32'(acc1[8:0]), 32'd508);
        chk("tp_wrap_ovf", 32'(ovf1[0]), 32'd1);
        sat_en = 1'b1;
        repeat (4) step(1, 0, 0, 255);
        idle(8);
        chk("tp_sat_acc", 32'(acc1[15*9 +: 9]), 32'd511);
        chk("tp_sat_ovf", 32'(ovf1[15]), 32'd1);
        sat_en = 1'b0;

        repeat (4) step(1, 0, 0, 5);
        repeat (4) step(1, 0, 0, 7);
        idle(8);
        chk("tp_b2b_acc", 32'(acc0[11:0]), 32'd28);

        repeat (2) step(1, 0, 0, 3);
        step(0, 1, 0, 0);
        repeat (4) step(1, 0, 0, 3);
        idle(8);
        chk("tp_rst_acc", 32'(acc0[11:0]), 32'd12);

        repeat (4) step(1, 0, 0, 9);
        idle(8);
        chk("tp_win1_acc", 32'(acc2[12 +: 12]), 32'd9);
        chk("tp_win1_sel", 32'(sel2), 32'd0);

        for (int blk = 0; blk < 6; blk++) begin
            sat_en = blk[0];
            repeat (50) step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, 1, 0);
            while (nb % 4 != 0) step(1, 0, 1, 0);
            idle(8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
